// File: rtl/spatz_boot_seq_pkg.sv
// Shared types for the cluster boot sequencer: FSM state encoding and the
// boot-control address computation.
package spatz_boot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    RSP,
    WAKE,
    DONE,
    ERROR
  } boot_state_e;

  // Result is taken modulo 2^64; callers truncate to their address width.
  function automatic logic [63:0] boot_ctrl_addr(
    input logic [63:0] base,
    input logic [63:0] stride,
    input logic [63:0] offset,
    input logic [31:0] idx
  );
    return base + stride * {32'b0, idx} + offset;
  endfunction

endpackage

// File: rtl/spatz_cluster_boot_sequencer_counter.sv
// Free-running up counter with synchronous clear; used for the settle delay
// and for timing the wake pulse.
module spatz_cluster_boot_sequencer_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + Width'(1);
    end
  end

  assign q_o = r_cnt;

endmodule

// File: rtl/spatz_cluster_boot_sequencer.sv
// Boot sequencer: after a settle delay writes the entry point into every
// cluster's boot-control register over reqrsp, retries on error, then wakes cores.
module spatz_cluster_boot_sequencer
  import spatz_boot_seq_pkg::*;
#(
  parameter int unsigned NumClusters     = 1,
  parameter int unsigned NumCores        = 2,
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned DataWidth       = 64,
  parameter logic [63:0] PeriStartAddr   = 64'h0,
  parameter logic [63:0] BootCtrlOffset  = 64'h0,
  parameter logic [63:0] ClusterStride   = 64'h40000,
  parameter int unsigned WaitCycles      = 1000,
  parameter int unsigned MaxRetries      = 2,
  parameter int unsigned WakePulseCycles = 1,
  parameter bit          PerClusterWake  = 1'b0,
  parameter bit          AutoStart       = 1'b1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      start_i,
  input  logic [31:0]                               entry_point_i,
  output logic [AddrWidth-1:0]                      q_addr_o,
  output logic [DataWidth-1:0]                      q_data_o,
  output logic [DataWidth/8-1:0]                    q_strb_o,
  output logic                                      q_write_o,
  output logic                                      q_valid_o,
  input  logic                                      q_ready_i,
  input  logic                                      p_valid_i,
  input  logic                                      p_error_i,
  output logic                                      p_ready_o,
  output logic [NumClusters*NumCores-1:0]           debug_req_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic                                      error_o,
  output logic [($clog2(NumClusters) | 1)-1:0]      failed_idx_o
);

  localparam int unsigned IdxW    = $clog2(NumClusters) | 1;
  localparam int unsigned NumDbg  = NumClusters * NumCores;
  localparam int unsigned CntMax  = (WaitCycles > WakePulseCycles) ? WaitCycles : WakePulseCycles;
  localparam int unsigned CntW    = $clog2(CntMax + 1) + 1;
  localparam int unsigned RetryW  = $clog2(MaxRetries + 1) + 1;
  localparam logic [CntW-1:0] WaitLast = CntW'(WaitCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'(WakePulseCycles - 1);

  boot_state_e         r_state, w_state_next;
  logic [31:0]         r_entry, w_entry_next;
  logic [IdxW-1:0]     r_idx, w_idx_next;
  logic [RetryW-1:0]   r_retry, w_retry_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;
  logic [IdxW-1:0]     r_failed_idx, w_failed_idx_next;
  logic                r_auto, w_auto_next;

  logic [CntW-1:0]     w_cnt;
  logic                w_cnt_clear;
  logic                w_last;
  logic                w_start;
  logic [IdxW-1:0]     w_idx_inc;
  logic [AddrWidth-1:0] w_addr;
  logic [NumDbg-1:0]   w_cluster_mask;

  assign w_last    = (r_idx == IdxW'(NumClusters - 1));
  assign w_idx_inc = r_idx + IdxW'(1);
  assign w_addr    = AddrWidth'(boot_ctrl_addr(PeriStartAddr, ClusterStride, BootCtrlOffset, 32'(r_idx)));

  for (genvar gi = 0; gi < NumClusters; gi++) begin : g_wake_mask
    assign w_cluster_mask[gi*NumCores +: NumCores] = {NumCores{r_idx == IdxW'(gi)}};
  end

  // Any state change restarts the shared timer, so WAIT and WAKE both count from zero.
  assign w_cnt_clear = (w_state_next != r_state);

  spatz_cluster_boot_sequencer_counter #(
    .Width (CntW)
  ) i_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_cnt_clear),
    .en_i    (1'b1),
    .q_o     (w_cnt)
  );

  always_comb begin
    w_state_next      = r_state;
    w_entry_next      = r_entry;
    w_idx_next        = r_idx;
    w_retry_next      = r_retry;
    w_done_next       = r_done;
    w_error_next      = r_error;
    w_failed_idx_next = r_failed_idx;
    w_auto_next       = r_auto;
    w_start           = 1'b0;
    q_valid_o         = 1'b0;
    p_ready_o         = 1'b0;
    debug_req_o       = '0;

    case (r_state)
      IDLE:        w_start = start_i | r_auto;
      DONE, ERROR: w_start = start_i;
      WAIT: begin
        if (w_cnt == WaitLast) w_state_next = REQ;
      end
      REQ: begin
        q_valid_o = 1'b1;
        if (q_ready_i) w_state_next = RSP;
      end
      RSP: begin
        p_ready_o = 1'b1;
        if (p_valid_i) begin
          if (!p_error_i) begin
            w_retry_next = '0;
            if (PerClusterWake || w_last) begin
              w_state_next = WAKE;
            end else begin
              w_idx_next   = w_idx_inc;
              w_state_next = REQ;
            end
          end else if (r_retry < RetryW'(MaxRetries)) begin
            w_retry_next = r_retry + RetryW'(1);
            w_state_next = REQ;
          end else begin
            w_error_next      = 1'b1;
            w_failed_idx_next = r_idx;
            w_state_next      = ERROR;
          end
        end
      end
      WAKE: begin
        debug_req_o = PerClusterWake ? w_cluster_mask : '1;
        if (w_cnt == WakeLast) begin
          if (PerClusterWake && !w_last) begin
            w_idx_next   = w_idx_inc;
            w_state_next = REQ;
          end else begin
            w_done_next  = 1'b1;
            w_state_next = DONE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_start) begin
      w_entry_next      = entry_point_i;
      w_idx_next        = '0;
      w_retry_next      = '0;
      w_done_next       = 1'b0;
      w_error_next      = 1'b0;
      w_failed_idx_next = '0;
      w_auto_next       = 1'b0;
      w_state_next      = (WaitCycles == 0) ? REQ : WAIT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_entry      <= '0;
      r_idx        <= '0;
      r_retry      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_failed_idx <= '0;
      r_auto       <= AutoStart;
    end else begin
      r_state      <= w_state_next;
      r_entry      <= w_entry_next;
      r_idx        <= w_idx_next;
      r_retry      <= w_retry_next;
      r_done       <= w_done_next;
      r_error      <= w_error_next;
      r_failed_idx <= w_failed_idx_next;
      r_auto       <= w_auto_next;
    end
  end

  assign q_addr_o     = (r_state == REQ) ? w_addr : '0;
  assign q_data_o     = (r_state == REQ) ? DataWidth'(r_entry) : '0;
  assign q_strb_o     = (r_state == REQ) ? '1 : '0;
  assign q_write_o    = (r_state == REQ);
  assign busy_o       = (r_state == WAIT) || (r_state == REQ) || (r_state == RSP) || (r_state == WAKE);
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign failed_idx_o = r_failed_idx;

endmodule

// File: tb/tb_spatz_cluster_boot_sequencer.sv
// Directed bench: single-cluster timing/backpressure/reset instance plus a
// four-cluster per-cluster-wake instance exercising retries and abort.
module tb_spatz_cluster_boot_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: 1 cluster, WaitCycles=10, AutoStart ----------------
  logic        a_rst_n, a_start, a_q_ready, a_p_valid, a_p_error;
  logic [31:0] a_entry;
  logic [47:0] a_q_addr;
  logic [63:0] a_q_data;
  logic [7:0]  a_q_strb;
  logic        a_q_write, a_q_valid, a_p_ready, a_busy, a_done, a_error;
  logic [1:0]  a_debug;
  logic [0:0]  a_failed;

  spatz_cluster_boot_sequencer #(
    .NumClusters(1), .NumCores(2), .AddrWidth(48), .DataWidth(64),
    .PeriStartAddr(64'h0200_0000), .BootCtrlOffset(64'h10), .ClusterStride(64'h40000),
    .WaitCycles(10), .MaxRetries(2), .WakePulseCycles(1), .PerClusterWake(1'b0), .AutoStart(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .start_i(a_start), .entry_point_i(a_entry),
    .q_addr_o(a_q_addr), .q_data_o(a_q_data), .q_strb_o(a_q_strb), .q_write_o(a_q_write),
    .q_valid_o(a_q_valid), .q_ready_i(a_q_ready), .p_valid_i(a_p_valid), .p_error_i(a_p_error),
    .p_ready_o(a_p_ready), .debug_req_o(a_debug), .busy_o(a_busy), .done_o(a_done),
    .error_o(a_error), .failed_idx_o(a_failed)
  );

  int a_writes = 0;
  always @(negedge clk) if (a_rst_n && a_q_valid && a_q_ready) a_writes <= a_writes + 1;

  // ---------------- instance B: 4 clusters, per-cluster wake, retries ----------------
  localparam logic [63:0] C0 = 64'h1000_0008;
  localparam logic [63:0] C1 = 64'h1004_0008;
  localparam logic [63:0] C2 = 64'h1008_0008;
  localparam logic [63:0] C3 = 64'h100C_0008;
  localparam logic [63:0] EW = 64'h0100_0000_0000_0000;
  localparam logic [63:0] EK = 64'h0200_0000_0000_0000;

  logic        b_rst_n, b_start, b_q_ready, b_p_valid, b_p_error;
  logic [31:0] b_entry;
  logic [47:0] b_q_addr;
  logic [63:0] b_q_data;
  logic [7:0]  b_q_strb;
  logic        b_q_write, b_q_valid, b_p_ready, b_busy, b_done, b_error;
  logic [7:0]  b_debug;
  logic [2:0]  b_failed;

  spatz_cluster_boot_sequencer #(
    .NumClusters(4), .NumCores(2), .AddrWidth(48), .DataWidth(64),
    .PeriStartAddr(64'h1000_0000), .BootCtrlOffset(64'h8), .ClusterStride(64'h40000),
    .WaitCycles(2), .MaxRetries(2), .WakePulseCycles(2), .PerClusterWake(1'b1), .AutoStart(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start), .entry_point_i(b_entry),
    .q_addr_o(b_q_addr), .q_data_o(b_q_data), .q_strb_o(b_q_strb), .q_write_o(b_q_write),
    .q_valid_o(b_q_valid), .q_ready_i(b_q_ready), .p_valid_i(b_p_valid), .p_error_i(b_p_error),
    .p_ready_o(b_p_ready), .debug_req_o(b_debug), .busy_o(b_busy), .done_o(b_done),
    .error_o(b_error), .failed_idx_o(b_failed)
  );

  // Responder: errors are injected only for writes to cluster 1 while the budget lasts.
  logic        b_err_load = 1'b0;
  int          b_err_init = 0;
  int          b_errs = 0;
  logic [63:0] b_last_addr = '0;
  logic [7:0]  b_debug_prev = '0;
  int          b_wake_cycles = 0;
  logic [63:0] b_ev_q[$];

  always @(negedge clk) begin
    if (b_err_load) b_errs <= b_err_init;
    if (b_p_valid && b_p_ready && b_last_addr == C1 && b_errs != 0) begin
      b_p_error <= 1'b1;
      if (!b_err_load) b_errs <= b_errs - 1;
    end else begin
      b_p_error <= 1'b0;
    end
    if (b_q_valid && b_q_ready) begin
      b_last_addr <= 64'(b_q_addr);
      b_ev_q.push_back(EW | 64'(b_q_addr));
    end
    if (b_debug != 0) begin
      b_wake_cycles <= b_wake_cycles + 1;
      if (b_debug_prev == 0) b_ev_q.push_back(EK | 64'(b_debug));
    end
    b_debug_prev <= b_debug;
  end

  logic [63:0] exp_ok[10] = '{EW|C0, EK|64'h03, EW|C1, EW|C1, EW|C1, EK|64'h0C,
                              EW|C2, EK|64'h30, EW|C3, EK|64'hC0};

  task automatic run_b(input int errs, output int ev_base, output int wake_base);
    int fin;
    b_err_init = errs;
    b_err_load = 1'b1;
    tick();
    b_err_load = 1'b0;
    ev_base   = b_ev_q.size();
    wake_base = b_wake_cycles;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    fin = 0;
    for (int i = 0; i < 400; i++) begin
      if (b_done || b_error) begin
        fin = 1;
        break;
      end
      tick();
    end
    check_eq("b_finished", 64'(fin), 64'd1);
  endtask

  int ev_base, wake_base, w0;

  initial begin
    a_rst_n = 1'b0; a_start = 1'b0; a_entry = 32'h8000_0000;
    a_q_ready = 1'b1; a_p_valid = 1'b1; a_p_error = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_entry = 32'h8000_0000;
    b_q_ready = 1'b1; b_p_valid = 1'b1;
    repeat (2) tick();
    check_eq("rst_busy", 64'(a_busy), 0);
    check_eq("rst_qvalid", 64'(a_q_valid), 0);
    check_eq("rst_debug", 64'(a_debug), 0);
    check_eq("rst_done", 64'(a_done), 0);
    check_eq("rst_error", 64'(a_error), 0);

    // A: autostart boot and latency
    a_rst_n = 1'b1;
    tick();
    check_eq("a_busy_wait", 64'(a_busy), 1);
    repeat (9) tick();
    check_eq("a_wait_novalid", 64'(a_q_valid), 0);
    tick();
    check_eq("a_req_valid", 64'(a_q_valid), 1);
    check_eq("a_req_addr", 64'(a_q_addr), 64'h0200_0010);
    check_eq("a_req_data", a_q_data, 64'h0000_0000_8000_0000);
    check_eq("a_req_strb", 64'(a_q_strb), 64'hFF);
    check_eq("a_req_write", 64'(a_q_write), 1);
    tick();
    check_eq("a_rsp_pready", 64'(a_p_ready), 1);
    check_eq("a_rsp_novalid", 64'(a_q_valid), 0);
    check_eq("a_rsp_nodebug", 64'(a_debug), 0);
    tick();
    check_eq("a_wake", 64'(a_debug), 64'h3);
    tick();
    check_eq("a_wake_len", 64'(a_debug), 0);
    check_eq("a_done", 64'(a_done), 1);
    check_eq("a_idle_busy", 64'(a_busy), 0);
    check_eq("a_writes", 64'(a_writes), 1);

    // A: restart from DONE with new entry, ignored start while busy, backpressure
    w0 = a_writes;
    a_entry = 32'h1000; a_start = 1'b1; a_q_ready = 1'b0;
    tick();
    a_start = 1'b0;
    check_eq("a_restart_done_clr", 64'(a_done), 0);
    check_eq("a_restart_busy", 64'(a_busy), 1);
    a_entry = 32'hDEAD_BEEF; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (8) tick();
    check_eq("a_bp_wait", 64'(a_q_valid), 0);
    tick();
    check_eq("a_bp_data", a_q_data, 64'h1000);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("a_bp_valid", 64'(a_q_valid), 1);
      check_eq("a_bp_addr", 64'(a_q_addr), 64'h0200_0010);
      check_eq("a_bp_data_hold", a_q_data, 64'h1000);
    end
    a_q_ready = 1'b1;
    tick();
    check_eq("a_bp_rsp", 64'(a_p_ready), 1);
    tick();
    check_eq("a_bp_wake", 64'(a_debug), 64'h3);
    tick();
    check_eq("a_bp_done", 64'(a_done), 1);
    check_eq("a_bp_writes", 64'(a_writes - w0), 1);

    // A: reset while waiting for a response, then autostart again
    a_p_valid = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (10) tick();
    check_eq("a_rr_req", 64'(a_q_valid), 1);
    tick();
    check_eq("a_rr_rsp", 64'(a_p_ready), 1);
    a_rst_n = 1'b0;
    #1;
    check_eq("a_rr_pready", 64'(a_p_ready), 0);
    check_eq("a_rr_busy", 64'(a_busy), 0);
    check_eq("a_rr_outs", {a_q_valid, a_debug, a_done, a_error}, 0);
    tick();
    a_rst_n = 1'b1; a_p_valid = 1'b1;
    tick();
    check_eq("a_rr_restart", 64'(a_busy), 1);
    check_eq("a_rr_restart_novalid", 64'(a_q_valid), 0);
    repeat (13) tick();
    check_eq("a_rr_done", 64'(a_done), 1);

    // B: no autostart; two errors on cluster 1 recover
    b_rst_n = 1'b1;
    repeat (3) tick();
    check_eq("b_no_autostart", 64'(b_busy), 0);
    run_b(2, ev_base, wake_base);
    check_eq("b_ok_done", 64'(b_done), 1);
    check_eq("b_ok_error", 64'(b_error), 0);
    check_eq("b_ok_nev", 64'(b_ev_q.size() - ev_base), 10);
    for (int i = 0; i < 10; i++)
      if (ev_base + i < b_ev_q.size()) check_eq("b_ok_ev", b_ev_q[ev_base + i], exp_ok[i]);
    check_eq("b_ok_wake_cycles", 64'(b_wake_cycles - wake_base), 8);

    // B: three errors on cluster 1 abort
    run_b(3, ev_base, wake_base);
    check_eq("b_err_error", 64'(b_error), 1);
    check_eq("b_err_done", 64'(b_done), 0);
    check_eq("b_err_idx", 64'(b_failed), 1);
    check_eq("b_err_busy", 64'(b_busy), 0);
    check_eq("b_err_nev", 64'(b_ev_q.size() - ev_base), 5);
    for (int i = 0; i < 5; i++)
      if (ev_base + i < b_ev_q.size()) check_eq("b_err_ev", b_ev_q[ev_base + i], exp_ok[i]);
    repeat (4) tick();
    check_eq("b_err_wake_cycles", 64'(b_wake_cycles - wake_base), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
